tx_arbiter: RTL



---
 rtl/tx_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// Round-robin scheduler feeding one byte-serial transmitter: one send strobe per frame,
// byte held for the whole frame, next grant decided on the frame's last cycle.
module tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int FRAME_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               send,
    output logic [7:0]         data,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy
);

    localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   last_grant_q;
    logic              arb;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [7:0]        win_byte;
    int                s;

    // Scan from farthest to nearest so the nearest requester after last_grant overwrites.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        s       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            s = (int'(last_grant_q) + k) % N_REQ;
            if (req[ID_W'(s)]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(s);
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) win_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        arb     = 1'b0;
        case (state_q)
            IDLE:    arb = 1'b1;
            SEND:    state_d = WAIT;
            WAIT:    arb = (cnt_q == CNT_LAST);
            default: state_d = IDLE;
        endcase
        if (arb) state_d = win_vld ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            data         <= '0;
            grant_id     <= '0;
        end else begin
            state_q <= state_d;
            // The SEND cycle is frame cycle 0; WAIT counts 1..FRAME_CYCLES-1.
            cnt_q   <= (state_d == WAIT) ? cnt_q + 1'b1 : '0;
            if (arb && win_vld) begin
                data         <= win_byte;
                grant_id     <= win_id;
                last_grant_q <= win_id;
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == SEND) ack[grant_id] = 1'b1;
    end

    assign send = (state_q == SEND);
    assign busy = (state_q != IDLE);

endmodule
